// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between two masters.
// Sequences the enable/ready handshake and aborts hung accesses by watchdog.
module sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 64,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_rd0,
    input  logic               req_wr0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [WDATA_W-1:0] wdata0,
    input  logic               req_rd1,
    input  logic               req_wr1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [WDATA_W-1:0] wdata1,
    output logic               ack0,
    output logic               ack1,
    output logic [RDATA_W-1:0] rdata,
    output logic               ready0,
    output logic               ready1,
    output logic               err,
    output logic               sram_read_en,
    output logic               sram_write_en,
    output logic [ADDR_W-1:0]  sram_address,
    output logic [WDATA_W-1:0] sram_write_data,
    input  logic [RDATA_W-1:0] sram_read_data,
    input  logic               sram_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               gnt_q, gnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WDATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               err_q, err_d;
    logic [RDATA_W-1:0] rdata_q, rdata_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;

    logic req0, req1, r0, r1;

    assign req0 = req_rd0 | req_wr0;
    assign req1 = req_rd1 | req_wr1;
    // A request still high in its own ack cycle is the stale one just served.
    assign r0   = req0 & ~ack0_q;
    assign r1   = req1 & ~ack1_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        unique case (state_q)
            IDLE: begin
                if (r0 | r1) begin
                    gnt_d = (r0 & r1) ? ~last_q : r1;
                    if (gnt_d) begin
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        wr_d    = req_wr1;
                    end else begin
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        wr_d    = req_wr0;
                    end
                    rd_en_d = ~wr_d;
                    wr_en_d = wr_d;
                    cnt_d   = 8'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (sram_ready || cnt_q == CntLast) begin
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    err_d   = ~sram_ready;
                    if (sram_ready && !wr_q) rdata_d = sram_read_data;
                    last_d  = gnt_q;
                    cnt_d   = 8'd0;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 8'd0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign ack0            = ack0_q;
    assign ack1            = ack1_q;
    assign err             = err_q;
    assign rdata           = rdata_q;
    assign ready0          = ~req0 | ack0_q;
    assign ready1          = ~req1 | ack1_q;
    assign sram_read_en    = rd_en_q;
    assign sram_write_en   = wr_en_q;
    assign sram_address    = addr_q;
    assign sram_write_data = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM controller.
// Expected acks are queued at stimulus time and matched as acks appear.
module tb_sram_arbiter;

    localparam int TO = 6;

    typedef struct {
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        int          ncyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_rd, req_wr;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        ack0, ack1, ready0, ready1, err;
    logic [63:0] rdata;
    logic        sram_read_en, sram_write_en, sram_ready;
    logic [31:0] sram_address, sram_write_data;
    logic [63:0] sram_read_data;

    int          nchk = 0;
    int          nerr = 0;
    exp_t        sb[$];
    logic [63:0] exp_rdata = '0;
    int          lat = 1;
    bit          hang = 0;
    int          en_cnt;
    int          last_lat;

    int          en_cycles = 0;
    bit          moved = 0;
    logic [31:0] cap_addr, cap_wd;
    bit          cap_wr;
    exp_t        me;

    sram_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_rd0(req_rd[0]), .req_wr0(req_wr[0]),
        .addr0(addr[0]), .wdata0(wdata[0]),
        .req_rd1(req_rd[1]), .req_wr1(req_wr[1]),
        .addr1(addr[1]), .wdata1(wdata[1]),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .ready0(ready0), .ready1(ready1), .err(err),
        .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rd_line(input logic [31:0] a);
        if (a == 32'h104) return 64'h1122_3344_5566_7788;
        return {~a, a ^ 32'h5A5A_0F0F};
    endfunction

    // SRAM controller: ready after `lat` WAIT cycles unless hung
    always @(posedge clk or negedge rst)
        if (!rst) en_cnt <= 0;
        else if (sram_read_en | sram_write_en) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;

    always_comb begin
        sram_ready     = !(sram_read_en | sram_write_en) || (!hang && en_cnt >= lat);
        sram_read_data = rd_line(sram_address);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input bit p, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit e, input int n);
        exp_t x;
        x.port = p; x.wr = wr; x.addr = a; x.wdata = d; x.err = e; x.ncyc = n;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            en_cycles = 0;
            moved = 0;
        end else begin
            if ((req_rd[0] | req_wr[0]) && !ack0) check("ready0_freeze", ready0, 0);
            if ((req_rd[1] | req_wr[1]) && !ack1) check("ready1_freeze", ready1, 0);
            if (err && !(ack0 || ack1)) check("stray_err", 1, 0);
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", 1, 0);
                end else begin
                    me = sb.pop_front();
                    check("ack_port", ack1, me.port);
                    check("dual_ack", ack0 & ack1, 0);
                    check("err", err, me.err);
                    if (!me.err && !me.wr) exp_rdata = rd_line(me.addr);
                    check("rdata", rdata, exp_rdata);
                    check("en_cycles", en_cycles, me.ncyc);
                    check("op", cap_wr, me.wr);
                    check("addr", cap_addr, me.addr);
                    check("addr_stable", moved, 0);
                    if (me.wr) check("wdata", cap_wd, me.wdata);
                end
            end
            if (sram_read_en || sram_write_en) begin
                if (sram_read_en && sram_write_en) check("both_en", 1, 0);
                en_cycles++;
                if (en_cycles == 1) begin
                    cap_addr = sram_address;
                    cap_wd   = sram_write_data;
                    cap_wr   = sram_write_en;
                end else if (sram_address != cap_addr || sram_write_data != cap_wd) begin
                    moved = 1;
                end
            end else begin
                en_cycles = 0;
                moved = 0;
            end
        end
    end

    task automatic run_port(input int p, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            bit got;
            got = 0;
            req_wr[p] = wr;
            req_rd[p] = !wr;
            addr[p]   = a + 32'(k * 8);
            wdata[p]  = d + 32'(k);
            for (int c = 0; c < 200 && !got; c++) begin
                @(posedge clk);
                #1;
                if ((p == 1) ? ack1 : ack0) begin
                    got = 1;
                    last_lat = c + 1;
                end
            end
            if (!got) check("ack_timeout", 0, 1);
            else check("ready_in_ack", (p == 1) ? ready1 : ready0, 1);
            req_wr[p] = 0;
            req_rd[p] = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        exp_rdata = '0;
        rst = 1;
    endtask

    initial begin
        rst = 0;
        req_rd = '0; req_wr = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_en", {sram_read_en, sram_write_en}, 0);
        check("rst_addr", sram_address, 0);
        check("rst_wdata", sram_write_data, 0);
        check("rst_ready", {ready0, ready1}, 2'b11);
        rst = 1;
        @(posedge clk); #1;

        // single read, 5 WAIT cycles
        lat = 5;
        push(0, 0, 32'h104, 0, 0, 6);
        run_port(0, 0, 32'h104, 0, 1);
        check("rdata_t1", rdata, 64'h1122_3344_5566_7788);

        // simultaneous after reset: port 0 wins the first tie
        apply_reset();
        lat = 2;
        push(0, 1, 32'h20, 32'hDEAD_BEEF, 0, 3);
        push(1, 0, 32'h40, 0, 0, 3);
        fork
            run_port(0, 1, 32'h20, 32'hDEAD_BEEF, 1);
            run_port(1, 0, 32'h40, 0, 1);
        join

        // continuous contention alternates
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            push(0, 0, 32'h100 + 32'(k * 8), 0, 0, 2);
            push(1, 1, 32'h200 + 32'(k * 8), 32'hCAFE_0000 + 32'(k), 0, 2);
        end
        fork
            run_port(0, 0, 32'h100, 0, 3);
            run_port(1, 1, 32'h200, 32'hCAFE_0000, 3);
        join

        // address change during WAIT is ignored
        lat = 5;
        push(0, 0, 32'h10, 0, 0, 6);
        fork
            run_port(0, 0, 32'h10, 0, 1);
            begin
                repeat (4) @(posedge clk);
                #2 addr[0] = 32'h30;
            end
        join

        // ready on the last watchdog cycle still completes
        lat = TO;
        push(1, 0, 32'h88, 0, 0, TO + 1);
        run_port(1, 0, 32'h88, 0, 1);

        // hung controller: abort with err, rdata kept
        hang = 1;
        push(0, 0, 32'h300, 0, 1, TO + 1);
        run_port(0, 0, 32'h300, 0, 1);
        hang = 0;
        check("rdata_after_abort", rdata, rd_line(32'h88));
        @(posedge clk); #1;

        // minimum latency on a normal access after abort
        lat = 1;
        push(0, 0, 32'h500, 0, 0, 2);
        run_port(0, 0, 32'h500, 0, 1);
        check("min_latency", last_lat, 3);

        // asynchronous reset in WAIT
        hang = 1;
        req_rd[0] = 1;
        addr[0] = 32'h600;
        repeat (4) @(posedge clk);
        #3 rst = 0;
        #1;
        check("arst_en", {sram_read_en, sram_write_en}, 0);
        check("arst_ack", {ack0, ack1}, 0);
        check("arst_err", err, 0);
        check("arst_rdata", rdata, 0);
        sb.delete();
        exp_rdata = '0;
        req_rd[0] = 0;
        hang = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {sram_read_en, sram_write_en, ack0, ack1}, 0);
        lat = 2;
        push(1, 0, 32'h700, 0, 0, 3);
        run_port(1, 0, 32'h700, 0, 1);
        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
